spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
SPI master controller, mode 0 (CPOL=0, CPHA=0), placed directly upstream of the byte shift stage. It accepts one DATA_W-bit word from the host over a valid/ready handshake. It then generates cs_n, sclk and mosi MSB-first, samples miso, and returns the received word with a one-cycle rx_valid pulse.

Parameters:
DATA_W, 8, bits per transfer (>=2)
CLK_DIV, 4, clk cycles per sclk half-period (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
tx_valid  input  1  host has a word to send
tx_ready  output  1  controller can accept a word (IDLE only)
tx_data  input  DATA_W  word to transmit, MSB first
rx_valid  output  1  one-cycle pulse: rx_data holds a completed word
rx_data  output  DATA_W  last received word, held until the next completion
busy  output  1  high in any state other than IDLE
sclk  output  1  SPI clock
cs_n  output  1  chip select, active low
mosi  output  1  serial data out
miso  input  1  serial data in

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, sclk=0, cs_n=1, mosi=0, tx_ready=1, busy=0, rx_valid=0, rx_data=0, counters=0. Reset mid-transfer aborts immediately; no rx_valid is produced.
- States: IDLE -> LEAD -> XFER -> TRAIL -> IDLE.
- IDLE:
  - tx_ready=1, cs_n=1, sclk=0.
  - On a clk edge with tx_valid && tx_ready: latch tx_data into the tx shift register, cs_n<=0, mosi<=tx_data[DATA_W-1], clear rx shift register, go to LEAD.
  - tx_data is sampled only on the accept edge.
- LEAD: CLK_DIV cycles with cs_n=0 and sclk=0 (setup time). Then go to XFER.
- XFER:
  - sclk toggles every CLK_DIV cycles, giving DATA_W full periods = 2*DATA_W*CLK_DIV cycles.
  - On each sclk 0->1 toggle: shift miso into the rx shift register LSB (left shift).
  - On each sclk 1->0 toggle, except the last: shift the tx register left and drive the next bit on mosi.
  - After the DATA_W-th falling toggle (sclk=0), go to TRAIL. mosi holds the LSB.
- TRAIL: CLK_DIV cycles with cs_n=0 and sclk=0 (hold time). Then:
  - cs_n<=1, rx_data<=rx shift register, rx_valid<=1 for exactly one cycle.
  - mosi<=0, state=IDLE.
- Latency: rx_valid is high on the first IDLE cycle, (2*DATA_W+2)*CLK_DIV clk edges after the accept edge. This is 72 cycles at the defaults.
- Back-to-back transfers:
  - tx_ready rises together with rx_valid, so the next word can be accepted in that same cycle.
  - cs_n is therefore high for at least 1 clk cycle between words.
- tx_valid while busy is ignored: tx_ready=0 and no state change. The host must hold tx_valid until the handshake completes.
- tx_data, tx_valid and miso changes in LEAD/XFER/TRAIL do not affect the transmitted word. miso is sampled only at rising toggles.
- Counter widths:
  - Divider counter: wide enough for CLK_DIV-1.
  - Bit counter: wide enough for DATA_W.
  - Both clear when leaving each state; no wrap-around inside a state.
- CLK_DIV=1: sclk toggles every clk cycle. The state sequence and latency formula are unchanged.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then idle for 10 cycles -> cs_n=1, sclk=0, mosi=0, tx_ready=1, busy=0, rx_valid=0.
- Send tx_data=8'hA5 with miso looped to mosi (defaults) -> mosi bits 1,0,1,0,0,1,0,1 stable around each sclk rise; exactly 8 sclk rises; rx_valid pulses once, 72 cycles after accept, with rx_data=8'hA5.
- Send tx_data=8'h00 with a slave model driving 8'hAB MSB-first on falling edges -> rx_data=8'hAB; cs_n low for exactly 72 cycles.
- Back-to-back 8'h3C then 8'hC3, tx_valid held high (loopback) -> second accept coincides with the first rx_valid; cs_n high for exactly 1 cycle between words; rx_data 8'h3C then 8'hC3.
- Assert reset at cycle 30 of a transfer (after 3 sclk rises) -> same cycle: cs_n=1, sclk=0, busy=0; no rx_valid; the next transfer completes correctly.
- CLK_DIV=1, DATA_W=16, tx_data=16'hBEEF (loopback) -> sclk period 2 cycles; rx_valid 34 cycles after accept; rx_data=16'hBEEF; toggling tx_valid during busy has no effect.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI mode-0 master: one word per host handshake, MSB first
module spi_master_ctrl #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    // Holds only the bits not yet on mosi; the MSB goes straight to mosi on accept.
    logic [DATA_W-2:0]   tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                tx_ready_q, tx_ready_d;
    logic                busy_q, busy_d;
    logic                sclk_q, sclk_d;
    logic                cs_n_q, cs_n_d;
    logic                mosi_q, mosi_d;
    logic                div_last;

    assign div_last = (div_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        mosi_d     = mosi_q;

        case (state_q)
            IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    tx_sh_d = tx_data[DATA_W-2:0];
                    mosi_d  = tx_data[DATA_W-1];
                    cs_n_d  = 1'b0;
                    rx_sh_d = '0;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = LEAD;
                end
            end
            LEAD: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = XFER;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            XFER: begin
                if (div_last) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
                    end else if (bit_q == BIT_W'(DATA_W - 1)) begin
                        // Last falling edge: mosi keeps the LSB through the hold time.
                        bit_d   = '0;
                        state_d = TRAIL;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        mosi_d  = tx_sh_q[DATA_W-2];
                        tx_sh_d = tx_sh_q << 1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            TRAIL: begin
                if (div_last) begin
                    div_d      = '0;
                    cs_n_d     = 1'b1;
                    mosi_d     = 1'b0;
                    rx_data_d  = rx_sh_q;
                    rx_valid_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        tx_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign sclk     = sclk_q;
    assign cs_n     = cs_n_q;
    assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - self-checking bench for spi_master_ctrl (8b/div4 and 16b/div1)
module tb_spi_master_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DATA_W=8, CLK_DIV=4
    logic        rst_a, tx_valid_a, tx_ready_a, rx_valid_a, busy_a, sclk_a, cs_n_a, mosi_a, miso_a;
    logic [7:0]  tx_data_a, rx_data_a;
    // Instance B: DATA_W=16, CLK_DIV=1
    logic        rst_b, tx_valid_b, tx_ready_b, rx_valid_b, busy_b, sclk_b, cs_n_b, mosi_b, miso_b;
    logic [15:0] tx_data_b, rx_data_b;

    spi_master_ctrl #(.DATA_W(8), .CLK_DIV(4)) dut_a (
        .clk(clk), .reset(rst_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .tx_data(tx_data_a), .rx_valid(rx_valid_a), .rx_data(rx_data_a), .busy(busy_a),
        .sclk(sclk_a), .cs_n(cs_n_a), .mosi(mosi_a), .miso(miso_a)
    );

    spi_master_ctrl #(.DATA_W(16), .CLK_DIV(1)) dut_b (
        .clk(clk), .reset(rst_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .tx_data(tx_data_b), .rx_valid(rx_valid_b), .rx_data(rx_data_b), .busy(busy_b),
        .sclk(sclk_b), .cs_n(cs_n_b), .mosi(mosi_b), .miso(miso_b)
    );

    // Slave model for A: loopback, or a fixed word shifted out MSB first on falling sclk
    bit         loop_a = 1'b1;
    logic [7:0] slave_a = 8'h00;
    int         sidx_a = 7;
    always @(negedge cs_n_a) sidx_a = 7;
    always @(negedge sclk_a) if (!cs_n_a) sidx_a = sidx_a - 1;
    assign miso_a = loop_a ? mosi_a : ((sidx_a >= 0) ? slave_a[sidx_a[2:0]] : 1'b0);
    assign miso_b = mosi_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];
    int          acc[2], rises[2], csl[2], hi_run[2], last_hi[2], rxv_cnt[2];
    logic [15:0] cur_tx[2];
    logic        psck[2];
    logic        coin[2];

    task automatic mon(input int id, input int w, input int div, input logic rst,
                       input logic txv, input logic txr, input logic rxv, input logic [15:0] rxd,
                       input logic sck, input logic csn, input logic mo, input logic [15:0] txd);
        logic [15:0] e;
        int lat;
        lat = (2 * w + 2) * div;
        if (!rst) begin
            psck[id] = 1'b0;
            if (id == 0) exp_q0.delete(); else exp_q1.delete();
            return;
        end
        if (csn) begin
            hi_run[id] = hi_run[id] + 1;
        end else begin
            if (hi_run[id] > 0) last_hi[id] = hi_run[id];
            hi_run[id] = 0;
            csl[id] = csl[id] + 1;
        end
        if (sck && !psck[id]) begin
            check("sclk_rise_time", cyc - acc[id], (2 + 2 * rises[id]) * div);
            if (rises[id] < w) check("mosi_bit", mo, cur_tx[id][w-1-rises[id]]);
            else check("extra_sclk_rise", rises[id], w - 1);
            rises[id] = rises[id] + 1;
        end
        psck[id] = sck;
        if (rxv) begin
            rxv_cnt[id] = rxv_cnt[id] + 1;
            coin[id] = txv && txr;
            if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
                check("rx_valid_unexpected", 1, 0);
            end else begin
                e = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                check("rx_data", rxd, e);
                check("rx_latency", cyc - acc[id], lat);
                check("sclk_rises", rises[id], w);
                check("cs_n_low_cycles", csl[id], lat);
            end
        end
        if (txv && txr) begin
            acc[id] = cyc + 1;
            cur_tx[id] = txd;
            rises[id] = 0;
            csl[id] = 0;
        end
    endtask

    always @(negedge clk) begin
        mon(0, 8, 4, rst_a, tx_valid_a, tx_ready_a, rx_valid_a, {8'h00, rx_data_a},
            sclk_a, cs_n_a, mosi_a, {8'h00, tx_data_a});
        mon(1, 16, 1, rst_b, tx_valid_b, tx_ready_b, rx_valid_b, rx_data_b,
            sclk_b, cs_n_b, mosi_b, tx_data_b);
    end

    task automatic wait_rx(input int id, input int target);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rxv_cnt[id] >= target) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("rx_timeout", rxv_cnt[id], target);
    endtask

    // Raise tx_valid, hold until the accept edge, then scramble tx_data while busy.
    task automatic send_a(input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        tx_valid_a = 1'b1;
        tx_data_a  = d;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_ready_a) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        tx_valid_a = 1'b0;
        tx_data_a  = 8'($urandom);
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [7:0] slv;
        bit         loopback;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[6];

    initial begin
        int n;
        vecs[0] = '{tx: 8'hA5, slv: 8'h00, loopback: 1'b1, exp: 8'hA5};
        vecs[1] = '{tx: 8'h00, slv: 8'hAB, loopback: 1'b0, exp: 8'hAB};
        vecs[2] = '{tx: 8'hFF, slv: 8'h00, loopback: 1'b0, exp: 8'h00};
        vecs[3] = '{tx: 8'h81, slv: 8'h00, loopback: 1'b1, exp: 8'h81};
        vecs[4] = '{tx: 8'h5A, slv: 8'h96, loopback: 1'b0, exp: 8'h96};
        vecs[5] = '{tx: 8'h01, slv: 8'h00, loopback: 1'b1, exp: 8'h01};

        for (int i = 0; i < 2; i++) begin
            acc[i] = 0; rises[i] = 0; csl[i] = 0; hi_run[i] = 0;
            last_hi[i] = 0; rxv_cnt[i] = 0; cur_tx[i] = '0; psck[i] = 1'b0; coin[i] = 1'b0;
        end
        rst_a = 1'b0; rst_b = 1'b0;
        tx_valid_a = 1'b0; tx_data_a = 8'h00;
        tx_valid_b = 1'b0; tx_data_b = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("idle_cs_n", cs_n_a, 1);
        check("idle_sclk", sclk_a, 0);
        check("idle_mosi", mosi_a, 0);
        check("idle_tx_ready", tx_ready_a, 1);
        check("idle_busy", busy_a, 0);
        check("idle_rx_valid", rx_valid_a, 0);
        check("idle_rx_data", rx_data_a, 0);
        check("idle_b_cs_n", cs_n_b, 1);
        check("idle_b_busy", busy_b, 0);

        for (int i = 0; i < 6; i++) begin
            loop_a  = vecs[i].loopback;
            slave_a = vecs[i].slv;
            n = rxv_cnt[0];
            exp_q0.push_back({8'h00, vecs[i].exp});
            send_a(vecs[i].tx);
            wait_rx(0, n + 1);
            repeat (3) @(negedge clk);
            check("single_rx_valid", rxv_cnt[0], n + 1);
        end

        // Back-to-back with tx_valid held high
        loop_a = 1'b1;
        n = rxv_cnt[0];
        exp_q0.push_back(16'h003C);
        exp_q0.push_back(16'h00C3);
        @(posedge clk); #1;
        tx_valid_a = 1'b1;
        tx_data_a  = 8'h3C;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_ready_a) break;
        end
        @(posedge clk); #1;
        tx_data_a = 8'hC3;
        wait_rx(0, n + 1);
        check("b2b_accept_with_rx_valid", coin[0], 1);
        @(posedge clk); #1;
        tx_valid_a = 1'b0;
        wait_rx(0, n + 2);
        check("b2b_cs_n_high_cycles", last_hi[0], 1);

        // Reset 30 cycles into a transfer
        n = rxv_cnt[0];
        exp_q0.push_back(16'h0055);
        send_a(8'h55);
        repeat (29) @(posedge clk);
        #1;
        rst_a = 1'b0;
        #1;
        check("abort_cs_n", cs_n_a, 1);
        check("abort_sclk", sclk_a, 0);
        check("abort_busy", busy_a, 0);
        check("abort_rises_seen", rises[0], 3);
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b1;
        repeat (100) @(negedge clk);
        check("abort_no_rx_valid", rxv_cnt[0], n);
        exp_q0.push_back(16'h00C9);
        send_a(8'hC9);
        wait_rx(0, n + 1);

        // Instance B: 16-bit, CLK_DIV=1, tx_valid toggled while busy
        n = rxv_cnt[1];
        exp_q1.push_back(16'hBEEF);
        @(posedge clk); #1;
        tx_valid_b = 1'b1;
        tx_data_b  = 16'hBEEF;
        @(negedge clk);
        check("b_tx_ready_before_accept", tx_ready_b, 1);
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            tx_valid_b = ~tx_valid_b;
            tx_data_b  = 16'($urandom);
            @(posedge clk); #1;
        end
        tx_valid_b = 1'b0;
        wait_rx(1, n + 1);
        repeat (10) @(negedge clk);
        check("b_single_rx_valid", rxv_cnt[1], n + 1);
        check("b_idle_after", busy_b, 0);
        check("b_rx_data_held", rx_data_b, 16'hBEEF);

        check("a_queue_drained", exp_q0.size(), 0);
        check("b_queue_drained", exp_q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
